// File: rtl/mul_seq_nbits.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_nbits
// Description : Iterative unsigned shift-and-add multiplier. Each BUSY cycle
//               retires BITS_PER_CYCLE multiplier bits, so a product takes
//               N = WIDTH/BITS_PER_CYCLE cycles. Valid/ready handshakes on
//               both the operand and product sides let the normalisation
//               stage stall the result.
//
// Parameters  : WIDTH          operand width; product is 2*WIDTH bits
//               BITS_PER_CYCLE multiplier bits consumed per BUSY cycle
//                              (must divide WIDTH)
//
// Ports       : i_clk       clock
//               i_rst       synchronous reset, active-high
//               i_valid     operands valid
//               o_ready     block can accept operands (IDLE)
//               i_data_one  multiplicand (WIDTH)
//               i_data_two  multiplier (WIDTH)
//               o_valid     product valid (DONE)
//               i_ready     downstream accepts product
//               o_data      unsigned product (2*WIDTH), held until the next
//                           product completes
//
// Options     : MUL_SEQ_EARLY_EXIT_EN - when defined, BUSY ends as soon as
//               the remaining multiplier bits are all zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_nbits #(
    parameter int WIDTH          = 24,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data_one,
    input  logic [WIDTH-1:0]     i_data_two,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_data
);

    localparam int c_steps = WIDTH / BITS_PER_CYCLE;
    localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

    generate
        if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bpc_check
            $error("mul_seq_nbits: WIDTH must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mult;
    logic [2*WIDTH-1:0]    r_acc;
    logic [c_cnt_w-1:0]    r_cnt;

    logic [2*WIDTH-1:0]    w_pp;
    logic [2*WIDTH-1:0]    w_acc_next;
    logic [WIDTH-1:0]      w_mult_next;
    logic                  w_last;

    // Partial product of the shifted multiplicand and the low multiplier
    // group. The group is zero-extended to full width so the multiply stays
    // 2*WIDTH bits; the true result never overflows that width.
    assign w_pp       = r_mcand * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}},
                                   r_mult[BITS_PER_CYCLE-1:0]};
    assign w_acc_next = r_acc + w_pp;

    // When a single cycle consumes the whole multiplier the shifted value is
    // simply zero; avoids a shift by the full register width.
    generate
        if (BITS_PER_CYCLE >= WIDTH) begin : g_shift_all
            assign w_mult_next = '0;
        end else begin : g_shift_part
            assign w_mult_next = r_mult >> BITS_PER_CYCLE;
        end
    endgenerate

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: the accumulator already holds the
    // complete product.
    assign w_last = (r_cnt == c_last) || (w_mult_next == '0);
`else
    assign w_last = (r_cnt == c_last);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_mult  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_mcand <= {{WIDTH{1'b0}}, i_data_one};
                        r_mult  <= i_data_two;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        o_ready <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << BITS_PER_CYCLE;
                    r_mult  <= w_mult_next;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        o_data  <= w_acc_next;
                        o_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // o_data deliberately keeps its value after release.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
